// File: rtl/trail_stack.sv
// trail_stack: assignment trail for the DPLL datapath.
// Records decisions and implications in order. On a conflict it unwinds to
// the most recent untried decision, flips it, and reports the decider
// position to resume from. If no untried decision remains it reports UNSAT.
module trail_stack #(
    parameter int MAX_VARS      = 64,
    parameter int MAX_VARS_BITS = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_valid,
    input  logic [MAX_VARS_BITS-1:0] push_var,
    input  logic                     push_val,
    input  logic                     push_is_dec,
    input  logic [MAX_VARS_BITS-1:0] push_dec_idx,
    output logic                     push_ready,
    input  logic                     bt_req,
    output logic                     unassign_valid,
    output logic [MAX_VARS_BITS-1:0] unassign_var,
    output logic                     assign_valid,
    output logic [MAX_VARS_BITS-1:0] assign_var,
    output logic                     assign_val,
    output logic                     bt_done,
    output logic                     bt_ok,
    output logic [MAX_VARS_BITS-1:0] bt_dec_idx,
    output logic                     unsat,
    output logic [MAX_VARS_BITS:0]   depth
);

    localparam int W = MAX_VARS_BITS;
    localparam logic [W-1:0] IDX_ONE  = W'(1);
    localparam logic [W:0]   DEPTH_ONE  = (W+1)'(1);
    localparam logic [W:0]   DEPTH_FULL = (W+1)'(MAX_VARS);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        FLIP,
        FAIL,
        HALT
    } state_t;

    state_t state;

    // Trail storage, one field per array; deliberately not reset.
    logic [W-1:0] ent_var     [MAX_VARS];
    logic         ent_val     [MAX_VARS];
    logic         ent_is_dec  [MAX_VARS];
    logic         ent_tried   [MAX_VARS];
    logic [W-1:0] ent_dec_idx [MAX_VARS];

    // Top-of-trail view; index wraps harmlessly when the trail is empty
    // because every consumer is gated by trail_empty.
    logic [W-1:0] top_idx;
    logic [W-1:0] push_idx;
    logic         trail_empty;
    logic         top_is_cand;
    logic         push_fire;
    logic         flip_fire;

    assign top_idx     = depth[W-1:0] - IDX_ONE;
    assign push_idx    = depth[W-1:0];
    assign trail_empty = (depth == '0);
    assign top_is_cand = ent_is_dec[top_idx] & ~ent_tried[top_idx];
    assign push_fire   = push_valid & push_ready;
    assign flip_fire   = (state == FLIP);

    // Per-entry write port: a push fills the slot at depth, a flip rewrites the top.
    generate
        for (genvar gi = 0; gi < MAX_VARS; gi++) begin : g_entry
            always_ff @(posedge clock) begin
                if (push_fire && push_idx == W'(gi)) begin
                    ent_var[gi]     <= push_var;
                    ent_val[gi]     <= push_val;
                    ent_is_dec[gi]  <= push_is_dec;
                    ent_tried[gi]   <= 1'b0;
                    ent_dec_idx[gi] <= push_dec_idx;
                end else if (flip_fire && top_idx == W'(gi)) begin
                    ent_val[gi]   <= ~ent_val[gi];
                    ent_tried[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Control FSM and trail depth; reset discards the trail immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            depth <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bt_req) begin
                        state <= POP;
                    end else if (push_fire) begin
                        depth <= depth + DEPTH_ONE;
                    end
                end
                POP: begin
                    if (trail_empty) begin
                        state <= FAIL;
                    end else if (top_is_cand) begin
                        state <= FLIP;
                    end else begin
                        depth <= depth - DEPTH_ONE;
                    end
                end
                FLIP:    state <= IDLE;
                FAIL:    state <= HALT;
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    // Moore outputs decoded from state, depth and the top entry.
    always_comb begin
        push_ready     = 1'b0;
        unassign_valid = 1'b0;
        unassign_var   = '0;
        assign_valid   = 1'b0;
        assign_var     = '0;
        assign_val     = 1'b0;
        bt_done        = 1'b0;
        bt_ok          = 1'b0;
        bt_dec_idx     = '0;
        unsat          = 1'b0;
        case (state)
            IDLE: begin
                push_ready = !bt_req && (depth < DEPTH_FULL);
            end
            POP: begin
                if (!trail_empty && !top_is_cand) begin
                    unassign_valid = 1'b1;
                    unassign_var   = ent_var[top_idx];
                end
            end
            FLIP: begin
                assign_valid = 1'b1;
                assign_var   = ent_var[top_idx];
                assign_val   = ~ent_val[top_idx];
                bt_done      = 1'b1;
                bt_ok        = 1'b1;
                bt_dec_idx   = ent_dec_idx[top_idx] + IDX_ONE;
            end
            FAIL: begin
                bt_done = 1'b1;
                unsat   = 1'b1;
            end
            HALT: begin
                unsat = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_trail_stack.sv
// Directed testbench for trail_stack with hand-computed expectations.
module tb_trail_stack;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       push_valid = 1'b0;
    logic [5:0] push_var = '0;
    logic       push_val = 1'b0;
    logic       push_is_dec = 1'b0;
    logic [5:0] push_dec_idx = '0;
    logic       push_ready;
    logic       bt_req = 1'b0;
    logic       unassign_valid;
    logic [5:0] unassign_var;
    logic       assign_valid;
    logic [5:0] assign_var;
    logic       assign_val;
    logic       bt_done;
    logic       bt_ok;
    logic [5:0] bt_dec_idx;
    logic       unsat;
    logic [6:0] depth;

    int checks = 0;
    int errors = 0;

    trail_stack #(.MAX_VARS(64), .MAX_VARS_BITS(6)) dut (
        .clock(clock),
        .reset(reset),
        .push_valid(push_valid),
        .push_var(push_var),
        .push_val(push_val),
        .push_is_dec(push_is_dec),
        .push_dec_idx(push_dec_idx),
        .push_ready(push_ready),
        .bt_req(bt_req),
        .unassign_valid(unassign_valid),
        .unassign_var(unassign_var),
        .assign_valid(assign_valid),
        .assign_var(assign_var),
        .assign_val(assign_val),
        .bt_done(bt_done),
        .bt_ok(bt_ok),
        .bt_dec_idx(bt_dec_idx),
        .unsat(unsat),
        .depth(depth)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [5:0] v, input logic val, input logic dec, input logic [5:0] didx);
        push_valid   = 1'b1;
        push_var     = v;
        push_val     = val;
        push_is_dec  = dec;
        push_dec_idx = didx;
        tick();
        push_valid   = 1'b0;
        $display("push var=%0d val=%0d dec=%0d dec_idx=%0d depth=%0d", v, val, dec, didx, depth);
    endtask

    task automatic start_bt();
        bt_req = 1'b1;
        tick();
        bt_req = 1'b0;
    endtask

    task automatic check_idle_quiet(input string tag);
        check({tag, "_unassign_valid"}, unassign_valid, 0);
        check({tag, "_assign_valid"}, assign_valid, 0);
        check({tag, "_bt_done"}, bt_done, 0);
        check({tag, "_unsat"}, unsat, 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        check("reset_depth", depth, 0);
        check("reset_push_ready", push_ready, 1);
        check_idle_quiet("reset");
        #1;
        reset = 1'b0;
        $display("reset pulse depth=%0d", depth);
    endtask

    initial begin
        // Reset values while reset is held.
        #1;
        check("por_depth", depth, 0);
        check("por_push_ready", push_ready, 1);
        check_idle_quiet("por");
        check("por_bt_dec_idx", bt_dec_idx, 0);
        #11;
        reset = 1'b0;

        // Push then count.
        push(6'd5, 1'b1, 1'b1, 6'd0);
        push(6'd9, 1'b0, 1'b0, 6'd0);
        push(6'd2, 1'b1, 1'b0, 6'd0);
        check("push3_depth", depth, 3);
        check("push3_ready", push_ready, 1);

        // Single flip.
        start_bt();
        $display("bt1 c1 unassign_valid=%0d var=%0d", unassign_valid, unassign_var);
        check("flip_c1_uv", unassign_valid, 1);
        check("flip_c1_var", unassign_var, 2);
        check("flip_c1_ready", push_ready, 0);
        tick();
        $display("bt1 c2 unassign_valid=%0d var=%0d", unassign_valid, unassign_var);
        check("flip_c2_uv", unassign_valid, 1);
        check("flip_c2_var", unassign_var, 9);
        tick();
        $display("bt1 c3 unassign_valid=%0d bt_done=%0d", unassign_valid, bt_done);
        check("flip_c3_uv", unassign_valid, 0);
        check("flip_c3_av", assign_valid, 0);
        check("flip_c3_done", bt_done, 0);
        tick();
        $display("bt1 c4 assign var=%0d val=%0d dec_idx=%0d ok=%0d", assign_var, assign_val, bt_dec_idx, bt_ok);
        check("flip_c4_av", assign_valid, 1);
        check("flip_c4_var", assign_var, 5);
        check("flip_c4_val", assign_val, 0);
        check("flip_c4_done", bt_done, 1);
        check("flip_c4_ok", bt_ok, 1);
        check("flip_c4_idx", bt_dec_idx, 1);
        check("flip_c4_depth", depth, 1);
        tick();
        check("flip_c5_ready", push_ready, 1);
        check("flip_c5_done", bt_done, 0);
        check("flip_c5_av", assign_valid, 0);

        // Tried decision is popped, then UNSAT.
        start_bt();
        $display("bt2 c1 unassign_valid=%0d var=%0d", unassign_valid, unassign_var);
        check("tried_c1_uv", unassign_valid, 1);
        check("tried_c1_var", unassign_var, 5);
        tick();
        check("tried_c2_uv", unassign_valid, 0);
        check("tried_c2_done", bt_done, 0);
        check("tried_c2_depth", depth, 0);
        tick();
        $display("bt2 c3 bt_done=%0d bt_ok=%0d unsat=%0d", bt_done, bt_ok, unsat);
        check("tried_c3_done", bt_done, 1);
        check("tried_c3_ok", bt_ok, 0);
        check("tried_c3_unsat", unsat, 1);
        tick();
        check("halt_done", bt_done, 0);
        check("halt_unsat", unsat, 1);
        check("halt_ready", push_ready, 0);
        push(6'd7, 1'b1, 1'b0, 6'd0);
        tick();
        check("halt_push_depth", depth, 0);
        check("halt_unsat2", unsat, 1);
        pulse_reset();

        // Nested decisions, with a push racing the backtrack request.
        push(6'd10, 1'b0, 1'b1, 6'd0);
        push(6'd11, 1'b1, 1'b0, 6'd0);
        push(6'd12, 1'b0, 1'b0, 6'd0);
        push(6'd20, 1'b1, 1'b1, 6'd3);
        push(6'd21, 1'b0, 1'b0, 6'd0);
        push(6'd22, 1'b1, 1'b0, 6'd0);
        check("nest_depth", depth, 6);
        bt_req       = 1'b1;
        push_valid   = 1'b1;
        push_var     = 6'd30;
        push_is_dec  = 1'b0;
        #1;
        check("simul_ready", push_ready, 0);
        tick();
        bt_req     = 1'b0;
        push_valid = 1'b0;
        $display("bt3 c1 unassign_valid=%0d var=%0d depth=%0d", unassign_valid, unassign_var, depth);
        check("simul_depth", depth, 6);
        check("nest_c1_uv", unassign_valid, 1);
        check("nest_c1_var", unassign_var, 22);
        tick();
        check("nest_c2_var", unassign_var, 21);
        tick();
        check("nest_c3_uv", unassign_valid, 0);
        check("nest_c3_depth", depth, 4);
        tick();
        $display("bt3 c4 assign var=%0d val=%0d dec_idx=%0d", assign_var, assign_val, bt_dec_idx);
        check("nest_c4_av", assign_valid, 1);
        check("nest_c4_var", assign_var, 20);
        check("nest_c4_val", assign_val, 0);
        check("nest_c4_idx", bt_dec_idx, 4);
        check("nest_c4_depth", depth, 4);
        tick();
        check("nest_c5_ready", push_ready, 1);

        // Reset mid-backtrack.
        push(6'd23, 1'b1, 1'b0, 6'd0);
        start_bt();
        check("mid_depth", depth, 5);
        check("mid_uv", unassign_valid, 1);
        check("mid_var", unassign_var, 23);
        pulse_reset();

        // Full trail.
        for (int i = 0; i < 64; i++) begin
            push(6'(i), 1'(i), 1'b0, 6'd0);
        end
        check("full_depth", depth, 64);
        check("full_ready", push_ready, 0);
        push(6'd63, 1'b1, 1'b0, 6'd0);
        check("full_drop_depth", depth, 64);
        pulse_reset();

        // Resume index wraps past the last decider position.
        push(6'd1, 1'b1, 1'b1, 6'd63);
        start_bt();
        check("wrap_c1_uv", unassign_valid, 0);
        tick();
        $display("bt4 c2 assign var=%0d val=%0d dec_idx=%0d", assign_var, assign_val, bt_dec_idx);
        check("wrap_c2_done", bt_done, 1);
        check("wrap_c2_ok", bt_ok, 1);
        check("wrap_c2_var", assign_var, 1);
        check("wrap_c2_idx", bt_dec_idx, 0);
        pulse_reset();

        // Empty trail fails at cycle 2.
        start_bt();
        check("empty_c1_done", bt_done, 0);
        tick();
        $display("bt5 c2 bt_done=%0d bt_ok=%0d unsat=%0d", bt_done, bt_ok, unsat);
        check("empty_c2_done", bt_done, 1);
        check("empty_c2_ok", bt_ok, 0);
        check("empty_c2_unsat", unsat, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
